// File: rtl/capture_controller_pkg.sv
// Pixel sensor configuration shared by the capture sequencer and its row streamer:
// array geometry, phase timing defaults, FSM state encoding and sizing helpers.
package capture_controller_pkg;

  localparam int PIXEL_ARRAY_HEIGHT = 4;
  localparam int PIXEL_ARRAY_WIDTH  = 4;
  localparam int PIXEL_BITS         = 8;
  localparam int ERASE_TIME         = 5;
  localparam int TIME_BITS          = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ERASE   = 3'd1,
    EXPOSE  = 3'd2,
    CONVERT = 3'd3,
    LATCH   = 3'd4,
    STREAM  = 3'd5
  } capture_state_t;

  function automatic int index_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  // Wide enough for the longest phase: erase, max expose, or a full ramp.
  function automatic int phase_counter_width(input int erase_time, input int time_bits,
                                             input int pixel_bits);
    int longest_s;
    int expose_max_s;
    int ramp_len_s;
    expose_max_s = (32'sd1 << time_bits) - 32'sd1;
    ramp_len_s   = 32'sd1 << pixel_bits;
    longest_s    = erase_time;
    longest_s    = (expose_max_s > longest_s) ? expose_max_s : longest_s;
    longest_s    = (ramp_len_s > longest_s) ? ramp_len_s : longest_s;
    return $clog2(longest_s + 32'sd1);
  endfunction

endpackage

// File: rtl/capture_controller_row_streamer.sv
// Row buffer and column sequencer: captures one row on load, then presents one
// pixel per valid/ready handshake with registered data and frame markers.
module capture_controller_row_streamer #(
  parameter int PIXEL_ARRAY_WIDTH = capture_controller_pkg::PIXEL_ARRAY_WIDTH,
  parameter int PIXEL_BITS        = capture_controller_pkg::PIXEL_BITS
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic                                  load,
  input  logic                                  first_row,
  input  logic                                  last_row,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] ROW_DATA,
  input  logic                                  OUT_READY,
  output logic [PIXEL_BITS-1:0]                 OUT_DATA,
  output logic                                  OUT_VALID,
  output logic                                  OUT_FIRST,
  output logic                                  OUT_LAST,
  output logic                                  row_done
);
  import capture_controller_pkg::*;

  localparam int COL_BITS = index_width(PIXEL_ARRAY_WIDTH);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(PIXEL_ARRAY_WIDTH - 1);

  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] buffer_r;
  logic [COL_BITS-1:0]                     col_r;
  logic [COL_BITS-1:0]                     col_next_s;
  logic                                    last_row_r;
  logic                                    handshake_s;

  assign handshake_s = OUT_VALID & OUT_READY;
  assign row_done    = handshake_s & (col_r == COL_LAST);
  assign col_next_s  = col_r + 1'b1;

  // Buffer capture on load; column advance and output update only on handshake.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      buffer_r   <= '0;
      col_r      <= '0;
      last_row_r <= 1'b0;
      OUT_DATA   <= '0;
      OUT_VALID  <= 1'b0;
      OUT_FIRST  <= 1'b0;
      OUT_LAST   <= 1'b0;
    end else if (load) begin
      buffer_r   <= ROW_DATA;
      col_r      <= '0;
      last_row_r <= last_row;
      OUT_DATA   <= ROW_DATA[PIXEL_BITS-1:0];
      OUT_VALID  <= 1'b1;
      OUT_FIRST  <= first_row;
      OUT_LAST   <= last_row & (COL_LAST == '0);
    end else if (handshake_s) begin
      if (col_r == COL_LAST) begin
        col_r     <= '0;
        OUT_DATA  <= '0;
        OUT_VALID <= 1'b0;
        OUT_FIRST <= 1'b0;
        OUT_LAST  <= 1'b0;
      end else begin
        col_r     <= col_next_s;
        OUT_DATA  <= buffer_r[int'(col_next_s) * PIXEL_BITS +: PIXEL_BITS];
        OUT_FIRST <= 1'b0;
        OUT_LAST  <= last_row_r & (col_next_s == COL_LAST);
      end
    end else begin
      col_r <= col_r;
    end
  end

endmodule

// File: rtl/capture_controller.sv
// Frame sequencer: on request runs erase, expose, ramp convert and row-by-row
// readout; all outputs are registered from the next-state decode.
module capture_controller #(
  parameter int PIXEL_ARRAY_HEIGHT = capture_controller_pkg::PIXEL_ARRAY_HEIGHT,
  parameter int PIXEL_ARRAY_WIDTH  = capture_controller_pkg::PIXEL_ARRAY_WIDTH,
  parameter int PIXEL_BITS         = capture_controller_pkg::PIXEL_BITS,
  parameter int ERASE_TIME         = capture_controller_pkg::ERASE_TIME,
  parameter int TIME_BITS          = capture_controller_pkg::TIME_BITS
) (
  input  logic                                    CLK,
  input  logic                                    RESET,
  input  logic                                    START,
  input  logic                                    CONTINUOUS,
  input  logic [TIME_BITS-1:0]                    EXPOSE_TIME,
  output logic                                    BUSY,
  output logic                                    PIXEL_ERASE,
  output logic                                    PIXEL_EXPOSE,
  output logic                                    PIXEL_ANALOG_RAMP_EN,
  output logic [PIXEL_BITS-1:0]                   PIXEL_CONVERT_COUNTER,
  output logic [PIXEL_ARRAY_HEIGHT-1:0]           SENSOR_ROW_SELECT,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] ROW_DATA,
  output logic [PIXEL_BITS-1:0]                   OUT_DATA,
  output logic                                    OUT_VALID,
  input  logic                                    OUT_READY,
  output logic                                    OUT_FIRST,
  output logic                                    OUT_LAST,
  output logic                                    FRAME_DONE
);
  import capture_controller_pkg::*;

  localparam int CNT_BITS = phase_counter_width(ERASE_TIME, TIME_BITS, PIXEL_BITS);
  localparam int ROW_BITS = index_width(PIXEL_ARRAY_HEIGHT);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_ERASE   = ERASE;
  localparam logic [2:0] S_EXPOSE  = EXPOSE;
  localparam logic [2:0] S_CONVERT = CONVERT;
  localparam logic [2:0] S_LATCH   = LATCH;
  localparam logic [2:0] S_STREAM  = STREAM;

  localparam logic [CNT_BITS-1:0] ERASE_LAST   = CNT_BITS'(ERASE_TIME - 32'sd1);
  localparam logic [CNT_BITS-1:0] CONVERT_LAST = CNT_BITS'((32'sd1 << PIXEL_BITS) - 32'sd1);
  localparam logic [ROW_BITS-1:0] ROW_LAST     = ROW_BITS'(PIXEL_ARRAY_HEIGHT - 32'sd1);

  logic [2:0]                    state_r, state_s;
  logic [CNT_BITS-1:0]           cnt_r, cnt_s;
  logic [ROW_BITS-1:0]           row_r, row_s;
  logic [TIME_BITS-1:0]          expose_len_r, expose_len_s, expose_norm_s;
  logic [CNT_BITS-1:0]           expose_last_s;
  logic [PIXEL_ARRAY_HEIGHT-1:0] row_onehot_s;
  logic                          done_s;
  logic                          row_done_s;

  // A zero exposure request still exposes for one cycle.
  assign expose_norm_s = (EXPOSE_TIME == '0) ? TIME_BITS'(32'd1) : EXPOSE_TIME;
  assign expose_last_s = CNT_BITS'(expose_len_r) - CNT_BITS'(32'd1);

  // Next-state, phase counter and row index decode.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    row_s        = row_r;
    expose_len_s = expose_len_r;
    done_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (START) begin
          state_s      = S_ERASE;
          cnt_s        = '0;
          expose_len_s = expose_norm_s;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ERASE: begin
        if (cnt_r == ERASE_LAST) begin
          state_s = S_EXPOSE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      S_EXPOSE: begin
        if (cnt_r == expose_last_s) begin
          state_s = S_CONVERT;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      S_CONVERT: begin
        if (cnt_r == CONVERT_LAST) begin
          state_s = S_LATCH;
          cnt_s   = '0;
          row_s   = '0;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      S_LATCH: begin
        state_s = S_STREAM;
      end
      S_STREAM: begin
        if (row_done_s) begin
          if (row_r == ROW_LAST) begin
            done_s = 1'b1;
            row_s  = '0;
            if (CONTINUOUS) begin
              state_s      = S_ERASE;
              cnt_s        = '0;
              expose_len_s = expose_norm_s;
            end else begin
              state_s = S_IDLE;
            end
          end else begin
            state_s = S_LATCH;
            row_s   = row_r + 1'b1;
          end
        end else begin
          state_s = S_STREAM;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
        row_s   = '0;
      end
    endcase
  end

  // One-hot row select for the row the next cycle will address.
  always_comb begin
    row_onehot_s        = '0;
    row_onehot_s[row_s] = 1'b1;
  end

  // State, counters and registered phase outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r               <= S_IDLE;
      cnt_r                 <= '0;
      row_r                 <= '0;
      expose_len_r          <= '0;
      BUSY                  <= 1'b0;
      PIXEL_ERASE           <= 1'b0;
      PIXEL_EXPOSE          <= 1'b0;
      PIXEL_ANALOG_RAMP_EN  <= 1'b0;
      PIXEL_CONVERT_COUNTER <= '0;
      SENSOR_ROW_SELECT     <= '0;
      FRAME_DONE            <= 1'b0;
    end else begin
      state_r               <= state_s;
      cnt_r                 <= cnt_s;
      row_r                 <= row_s;
      expose_len_r          <= expose_len_s;
      BUSY                  <= (state_s != S_IDLE);
      PIXEL_ERASE           <= (state_s == S_ERASE);
      PIXEL_EXPOSE          <= (state_s == S_EXPOSE);
      PIXEL_ANALOG_RAMP_EN  <= (state_s == S_CONVERT);
      PIXEL_CONVERT_COUNTER <= (state_s == S_CONVERT) ? cnt_s[PIXEL_BITS-1:0] : '0;
      SENSOR_ROW_SELECT     <= ((state_s == S_LATCH) || (state_s == S_STREAM)) ? row_onehot_s : '0;
      FRAME_DONE            <= done_s;
    end
  end

  capture_controller_row_streamer #(
    .PIXEL_ARRAY_WIDTH (PIXEL_ARRAY_WIDTH),
    .PIXEL_BITS        (PIXEL_BITS)
  ) u_row_streamer (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (state_r == S_LATCH),
    .first_row (row_r == '0),
    .last_row  (row_r == ROW_LAST),
    .ROW_DATA  (ROW_DATA),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_FIRST (OUT_FIRST),
    .OUT_LAST  (OUT_LAST),
    .row_done  (row_done_s)
  );

endmodule

// File: tb/tb_capture_controller.sv
// Directed bench for capture_controller with a 2x2 array: table-driven frames
// plus continuous, mid-frame reset and reset-with-start sequences.
module tb_capture_controller;

  logic        CLK = 1'b0;
  logic        RESET, START, CONTINUOUS, OUT_READY;
  logic [9:0]  EXPOSE_TIME;
  logic        BUSY, PIXEL_ERASE, PIXEL_EXPOSE, PIXEL_ANALOG_RAMP_EN;
  logic [7:0]  PIXEL_CONVERT_COUNTER;
  logic [1:0]  SENSOR_ROW_SELECT;
  logic [15:0] ROW_DATA;
  logic [7:0]  OUT_DATA;
  logic        OUT_VALID, OUT_FIRST, OUT_LAST, FRAME_DONE;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  capture_controller #(
    .PIXEL_ARRAY_HEIGHT (2),
    .PIXEL_ARRAY_WIDTH  (2),
    .PIXEL_BITS         (8),
    .ERASE_TIME         (5),
    .TIME_BITS          (10)
  ) dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .START                 (START),
    .CONTINUOUS            (CONTINUOUS),
    .EXPOSE_TIME           (EXPOSE_TIME),
    .BUSY                  (BUSY),
    .PIXEL_ERASE           (PIXEL_ERASE),
    .PIXEL_EXPOSE          (PIXEL_EXPOSE),
    .PIXEL_ANALOG_RAMP_EN  (PIXEL_ANALOG_RAMP_EN),
    .PIXEL_CONVERT_COUNTER (PIXEL_CONVERT_COUNTER),
    .SENSOR_ROW_SELECT     (SENSOR_ROW_SELECT),
    .ROW_DATA              (ROW_DATA),
    .OUT_DATA              (OUT_DATA),
    .OUT_VALID             (OUT_VALID),
    .OUT_READY             (OUT_READY),
    .OUT_FIRST             (OUT_FIRST),
    .OUT_LAST              (OUT_LAST),
    .FRAME_DONE            (FRAME_DONE)
  );

  // Array model: selected row drives the bus; the bus is scrambled while a row
  // is streaming so only the latch-edge sample may reach the output.
  always_comb begin
    ROW_DATA = 16'h0000;
    if (SENSOR_ROW_SELECT[1]) ROW_DATA = 16'hD4C3;
    else if (SENSOR_ROW_SELECT[0]) ROW_DATA = 16'hB2A1;
    else ROW_DATA = 16'h0000;
    if (OUT_VALID) ROW_DATA = ~ROW_DATA;
  end

  typedef struct {
    logic [9:0] expose;
    int         stall_pix;
    int         stall_len;
    int         exp_len;
    int         exp_expose;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {BUSY, PIXEL_ERASE, PIXEL_EXPOSE, PIXEL_ANALOG_RAMP_EN, PIXEL_CONVERT_COUNTER,
               SENSOR_ROW_SELECT, OUT_DATA, OUT_VALID, OUT_FIRST, OUT_LAST, FRAME_DONE}, 32'd0);
  endtask

  // Runs one frame. With do_start=0 the caller is already in the first ERASE cycle.
  task automatic run_frame(input logic [9:0] et, input int stall_pix, input int stall_len,
                           input int exp_len, input int exp_expose, input bit do_start,
                           input bit exp_cont, input bit poke, input bit clear_cont);
    logic [7:0] exp_pix [4];
    int e, pix, stall_left, erase_n, expose_n, conv_n;
    exp_pix    = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    pix        = 0;
    stall_left = stall_len;
    erase_n    = 0;
    expose_n   = 0;
    conv_n     = 0;
    OUT_READY  = 1'b1;
    if (do_start) begin
      @(negedge CLK);
      START       = 1'b1;
      EXPOSE_TIME = et;
      @(negedge CLK);
      START = 1'b0;
    end
    e = 0;
    chk("busy_at_t1", BUSY, 32'd1);
    chk("erase_at_t1", PIXEL_ERASE, 32'd1);
    while (!(FRAME_DONE && e > 0) && e < 3000) begin
      chk("one_phase", 32'($countones({PIXEL_ERASE, PIXEL_EXPOSE, PIXEL_ANALOG_RAMP_EN, OUT_VALID}) <= 1), 32'd1);
      chk("busy_in_frame", BUSY, 32'd1);
      erase_n  += int'(PIXEL_ERASE);
      expose_n += int'(PIXEL_EXPOSE);
      if (PIXEL_ANALOG_RAMP_EN) begin
        chk("ramp_value", PIXEL_CONVERT_COUNTER, 32'(conv_n[7:0]));
        conv_n++;
      end else begin
        chk("ramp_idle_zero", PIXEL_CONVERT_COUNTER, 32'd0);
      end
      OUT_READY = 1'b1;
      if (OUT_VALID) begin
        if (pix > 3) begin
          chk("extra_pixel", pix, 32'd3);
        end else begin
          chk("pixel_data", OUT_DATA, exp_pix[pix]);
          chk("pixel_first", OUT_FIRST, 32'(pix == 0));
          chk("pixel_last", OUT_LAST, 32'(pix == 3));
          chk("row_select", SENSOR_ROW_SELECT, (pix < 2) ? 32'd1 : 32'd2);
        end
        if (pix == stall_pix && stall_left > 0) begin
          OUT_READY = 1'b0;
          stall_left--;
        end else begin
          pix++;
        end
      end
      if (clear_cont && e == 10) CONTINUOUS = 1'b0;
      if (poke) START = (e == 100 || e == 270);
      @(negedge CLK);
      e++;
    end
    START     = 1'b0;
    OUT_READY = 1'b1;
    chk("frame_len", e, exp_len);
    chk("pixel_count", pix, 32'd4);
    chk("erase_cycles", erase_n, 32'd5);
    chk("expose_cycles", expose_n, exp_expose);
    chk("convert_cycles", conv_n, 32'd256);
    chk("done_valid_low", OUT_VALID, 32'd0);
    if (exp_cont) begin
      chk("done_with_erase", PIXEL_ERASE, 32'd1);
      chk("done_busy_cont", BUSY, 32'd1);
    end else begin
      chk("done_busy_low", BUSY, 32'd0);
      @(negedge CLK);
      chk("done_one_pulse", FRAME_DONE, 32'd0);
      chk("idle_after_frame", BUSY, 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int guard;
    vecs[0] = '{expose: 10'd10, stall_pix: -1, stall_len: 0, exp_len: 277, exp_expose: 10};
    vecs[1] = '{expose: 10'd10, stall_pix: 1,  stall_len: 3, exp_len: 280, exp_expose: 10};
    vecs[2] = '{expose: 10'd0,  stall_pix: -1, stall_len: 0, exp_len: 268, exp_expose: 1};
    vecs[3] = '{expose: 10'd3,  stall_pix: 3,  stall_len: 2, exp_len: 272, exp_expose: 3};

    RESET       = 1'b1;
    START       = 1'b0;
    CONTINUOUS  = 1'b0;
    OUT_READY   = 1'b1;
    EXPOSE_TIME = 10'd10;
    repeat (3) @(negedge CLK);
    chk_all_zero("reset_state");
    RESET = 1'b0;
    @(negedge CLK);
    chk_all_zero("idle_after_reset");

    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].expose, vecs[i].stall_pix, vecs[i].stall_len, vecs[i].exp_len,
                vecs[i].exp_expose, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Two back-to-back frames; stray START pulses must neither alter nor queue a frame.
    CONTINUOUS  = 1'b1;
    EXPOSE_TIME = 10'd10;
    run_frame(10'd10, -1, 0, 277, 10, 1'b1, 1'b1, 1'b1, 1'b0);
    run_frame(10'd10, -1, 0, 277, 10, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) begin
      @(negedge CLK);
      chk("no_queued_start", BUSY, 32'd0);
    end

    // Reset in the middle of the ramp.
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    guard = 0;
    while (!(PIXEL_ANALOG_RAMP_EN && PIXEL_CONVERT_COUNTER == 8'd100) && guard < 1000) begin
      @(negedge CLK);
      guard++;
    end
    chk("reach_ramp_100", 32'(guard < 1000), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    chk_all_zero("mid_frame_reset");
    RESET = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      chk("no_done_after_reset", {BUSY, FRAME_DONE}, 32'd0);
    end
    run_frame(10'd10, -1, 0, 277, 10, 1'b1, 1'b0, 1'b0, 1'b0);

    // START held through reset, then sampled at the first post-reset edge.
    @(negedge CLK);
    RESET = 1'b1;
    START = 1'b1;
    @(negedge CLK);
    chk("start_in_reset_busy", BUSY, 32'd0);
    chk("start_in_reset_erase", PIXEL_ERASE, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    run_frame(10'd10, -1, 0, 277, 10, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
